// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared constants, FSM/mode encodings and GF(2^8) helpers for the AES inverse round engine.
package aes_dec_pkg;
  localparam int NR_AES128 = 10;
  localparam int NR_AES256 = 14;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic {MODE_AES128 = 1'b0, MODE_AES256 = 1'b1} mode_e;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as InvSubBytes needs
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x240;
    x2 = gmul(x, x);
    x3 = gmul(x2, x);
    x12 = gmul(gmul(x3, x3), gmul(x3, x3));
    x240 = gmul(x12, x3);
    for (int i = 0; i < 4; i++) x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[1]^b[4]^b[6], b[0]^b[3]^b[5], b[7]^b[2]^b[4], b[6]^b[1]^b[3],
         b[5]^b[0]^b[2], b[4]^b[7]^b[1], b[3]^b[6]^b[0], b[2]^b[5]^b[7]} ^ 8'h05;
    return gf_inv(t);
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
endpackage

// File: rtl/inv_round_dp.sv
// inv_round_dp: combinational AES inverse round InvSubBytes(InvShiftRows([InvMixColumns](s ^ k))).
module inv_round_dp
  import aes_dec_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  input  logic         skip_mix_i,
  output logic [127:0] state_o
);
  logic [127:0] ak, mc, mx, sr;
  // byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4
  always_comb begin
    ak = state_i ^ key_i;
    mc = '0;
    for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
    mx = skip_mix_i ? ak : mc;
    sr = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        sr[127-8*(r+4*c) -: 8] = mx[127-8*(r+4*((c+4-r)%4)) -: 8];
    state_o = '0;
    for (int n = 0; n < 16; n++) state_o[127-8*n -: 8] = inv_sbox(sr[127-8*n -: 8]);
  end
endmodule

// File: rtl/aes_inv_round_engine.sv
// aes_inv_round_engine: iterative AES-128/256 decryption reusing one inverse round datapath.
module aes_inv_round_engine
  import aes_dec_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int KIDX_W       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] in_data,
  input  logic                    in_mode,
  output logic [KIDX_W-1:0]       key_idx,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_data,
  output logic                    busy
);
  state_e                  state_q;
  logic [KIDX_W-1:0]       round_q;
  logic [BLOCK_LENGTH-1:0] blk_q, blk_d, out_data_q;
  logic                    out_valid_q;
  logic                    idle;
  assign idle      = state_q == IDLE;
  assign in_ready  = idle;
  assign busy      = !idle;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign key_idx   = !rst ? KIDX_W'(NR_AES128) :
                     idle ? (in_mode == MODE_AES256 ? KIDX_W'(NR_AES256) : KIDX_W'(NR_AES128)) :
                     state_q == RUN ? round_q : '0;
  // the first operation on the raw ciphertext skips InvMixColumns
  inv_round_dp u_dp (
    .state_i   (idle ? in_data : blk_q),
    .key_i     (key_in),
    .skip_mix_i(idle),
    .state_o   (blk_d)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      round_q     <= '0;
      blk_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          blk_q   <= blk_d;
          round_q <= in_mode == MODE_AES256 ? KIDX_W'(NR_AES256 - 1) : KIDX_W'(NR_AES128 - 1);
          state_q <= RUN;
        end
        RUN: if (|round_q) begin
          blk_q   <= blk_d;
          round_q <= round_q - 1'b1;
        end else begin
          out_data_q  <= blk_q ^ key_in;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_round_engine.sv
// tb_aes_inv_round_engine: directed FIPS-197 vectors plus random blocks checked against a forward-cipher model.
module tb_aes_inv_round_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [127:0] in_data, key_in, out_data;
  logic [3:0]   key_idx;
  logic [127:0] rk_pend [0:15];
  logic [127:0] rk_fly  [0:15];
  logic [7:0]   sb [256];
  int           checks = 0;
  int           failures = 0;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_inv_round_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .key_idx(key_idx), .key_in(key_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // key store: offered block's schedule while idle, in-flight block's schedule otherwise
  assign key_in = in_ready ? rk_pend[key_idx] : rk_fly[key_idx];
  always @(posedge clk)
    if (rst && in_valid && in_ready)
      for (int i = 0; i < 16; i++) rk_fly[i] <= rk_pend[i];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int          nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gm(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subword(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ rk_pend[0];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int n = 0; n < 16; n++) s[n] = sb[v[127-8*n -: 8]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = s[r+4*((c+r)%4)];
      if (rnd != nr)
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      for (int n = 0; n < 16; n++) v[127-8*n -: 8] = t[n];
      v = v ^ rk_pend[rnd];
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] ct, input logic m);
    in_data = ct;
    in_mode = m;
    in_valid = 1'b1;
    #1;
    chk("in_ready_idle", 128'(in_ready), 128'd1);
    chk("key_idx_idle", 128'(key_idx), m ? 128'd14 : 128'd10);
    step();
  endtask

  task automatic run_rounds(input logic m, input logic [127:0] pt, input logic hold);
    int nr = m ? 14 : 10;
    if (!hold) in_valid = 1'b0;
    for (int j = nr - 1; j >= 0; j--) begin
      chk("key_idx_run", 128'(key_idx), 128'(j));
      chk("busy_run", 128'(busy), 128'd1);
      chk("out_valid_run", 128'(out_valid), 128'd0);
      chk("in_ready_run", 128'(in_ready), 128'd0);
      if (hold) begin
        in_mode = 1'($urandom);
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    chk("out_valid_done", 128'(out_valid), 128'd1);
    chk("out_data", out_data, pt);
    chk("key_idx_done", 128'(key_idx), 128'd0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    chk("out_valid_consumed", 128'(out_valid), 128'd0);
    chk("in_ready_consumed", 128'(in_ready), 128'd1);
    chk("busy_consumed", 128'(busy), 128'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]   inv;
    logic [255:0] key;
    logic [127:0] pt, ct, last;
    logic         m;
    rst = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 16; i++) begin rk_pend[i] = '0; rk_fly[i] = '0; end
    #2;
    in_mode = 1'b1; in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_key_idx", 128'(key_idx), 128'd10);
    step();
    chk("rst_held_busy", 128'(busy), 128'd0);
    in_valid = 1'b0; in_mode = 1'b0;
    rst = 1'b1;
    step();

    expand(K1, 4);
    start(CT1, 1'b0);
    run_rounds(1'b0, PT, 1'b0);
    consume();

    expand(K3, 8);
    start(CT3, 1'b1);
    run_rounds(1'b1, PT, 1'b0);
    in_valid = 1'b1; in_data = CT1; in_mode = 1'b0;
    expand(K1, 4);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_out_data", out_data, PT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_busy", 128'(busy), 128'd1);
      step();
    end
    consume();
    start(CT1, 1'b0);
    run_rounds(1'b0, PT, 1'b0);
    consume();

    expand(K1, 4);
    out_ready = 1'b1;
    start(CT1, 1'b0);
    run_rounds(1'b0, PT, 1'b1);
    in_data = CT3; in_mode = 1'b1;
    expand(K3, 8);
    step();
    chk("b2b_out_valid", 128'(out_valid), 128'd0);
    chk("b2b_not_accepted", 128'(busy), 128'd0);
    chk("b2b_key_idx", 128'(key_idx), 128'd14);
    step();
    run_rounds(1'b1, PT, 1'b0);
    consume();

    expand(K1, 4);
    start(CT1, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_key_idx", 128'(key_idx), 128'd5);
    rst = 1'b0;
    #2;
    chk("async_out_valid", 128'(out_valid), 128'd0);
    chk("async_out_data", out_data, 128'd0);
    chk("async_in_ready", 128'(in_ready), 128'd1);
    chk("async_busy", 128'(busy), 128'd0);
    chk("async_key_idx", 128'(key_idx), 128'd10);
    step();
    rst = 1'b1;
    start(CT1, 1'b0);
    run_rounds(1'b0, PT, 1'b0);
    consume();

    last = out_data;
    for (int i = 0; i < 50; i++) begin
      out_ready = 1'($urandom);
      in_mode = 1'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("idle_key_idx", 128'(key_idx), in_mode ? 128'd14 : 128'd10);
      step();
      chk("idle_busy", 128'(busy), 128'd0);
      chk("idle_out_valid", 128'(out_valid), 128'd0);
      chk("idle_out_data", out_data, last);
    end
    out_ready = 1'b0;

    for (int b = 0; b < 6; b++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      expand(key, m ? 8 : 4);
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = enc(pt, m ? 14 : 10);
      start(ct, m);
      run_rounds(m, pt, 1'b0);
      for (int s = $urandom_range(0, 3); s > 0; s--) begin
        step();
        chk("rand_hold_valid", 128'(out_valid), 128'd1);
        chk("rand_hold_data", out_data, pt);
      end
      consume();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
